motor_pwm_driver: RTL

//   Consumer end of the balance loop. Takes the signed 16-bit Blance_pwm command and turns it

---
 rtl/motor_pwm_pkg.sv | 21 ++
 rtl/pwm_period_counter.sv | 33 +++
 rtl/motor_pwm_driver.sv | 101 ++++++++++
 3 files changed

// File: rtl/motor_pwm_pkg.sv
// Shared state encoding, widths and magnitude helper for the motor PWM driver.
package motor_pwm_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DEAD = 2'd2
  } state_t;

  localparam int unsigned CNT_W_DEF = 16;
  localparam int unsigned CMD_W     = 16;
  localparam int unsigned MAG_W     = CMD_W + 1;

  // Two's-complement magnitude; one extra bit so -32768 maps to +32768.
  function automatic logic [MAG_W-1:0] abs_mag(input logic [CMD_W-1:0] v);
    logic [MAG_W-1:0] ext;
    ext = {v[CMD_W-1], v};
    return v[CMD_W-1] ? (~ext + MAG_W'(1)) : ext;
  endfunction

endpackage

// File: rtl/pwm_period_counter.sv
// PWM period counter: wraps at PERIOD_CNT-1, held at 0 while cleared, flags the first clock of a period.
module pwm_period_counter
  import motor_pwm_pkg::*;
#(
  parameter int unsigned PERIOD_CNT = 7200,
  parameter int unsigned CNT_W      = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic             clear,
  output logic [CNT_W-1:0] cnt,
  output logic [CNT_W-1:0] cnt_next_c,
  output logic             wrap_c,
  output logic             period_start
);

  always_comb begin
    wrap_c     = (cnt == CNT_W'(PERIOD_CNT - 1));
    cnt_next_c = (clear || wrap_c) ? '0 : cnt + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt          <= '0;
      period_start <= 1'b0;
    end else begin
      cnt          <= cnt_next_c;
      period_start <= run && (cnt_next_c == '0);
    end
  end

endmodule

// File: rtl/motor_pwm_driver.sv
// Signed duty command to one PWM/direction channel, double-buffered on period boundaries.
// Optional reversal blanking enabled by defining PWM_DEADTIME_EN.
module motor_pwm_driver
  import motor_pwm_pkg::*;
#(
  parameter int unsigned PERIOD_CNT  = 7200,
  parameter int unsigned DUTY_MAX    = 7000,
  parameter int unsigned DEAD_CYCLES = 50,
  parameter int unsigned CNT_W       = CNT_W_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic signed [CMD_W-1:0] Blance_pwm,
  output logic                    pwm_out,
  output logic                    dir_out,
  output logic                    period_start,
  output logic [CNT_W-1:0]        duty_active
);

  state_t           state, state_n;
  logic [CMD_W-1:0] shadow;
  logic [MAG_W-1:0] mag_c;
  logic [CNT_W-1:0] duty_cmd_c, duty_n;
  logic [CNT_W-1:0] cnt, cnt_next_c;
  logic             wrap_c, dir_next_c, dir_n, pwm_n, load_c, dead_done_c;
  logic             run_c, clear_c;

  pwm_period_counter #(
    .PERIOD_CNT(PERIOD_CNT),
    .CNT_W     (CNT_W)
  ) u_counter (
    .clk         (clk),
    .rst         (rst),
    .run         (run_c),
    .clear       (clear_c),
    .cnt         (cnt),
    .cnt_next_c  (cnt_next_c),
    .wrap_c      (wrap_c),
    .period_start(period_start)
  );

  // Clamped magnitude and direction of the buffered command.
  always_comb begin
    mag_c       = abs_mag(shadow);
    duty_cmd_c  = (mag_c > MAG_W'(DUTY_MAX)) ? CNT_W'(DUTY_MAX) : CNT_W'(mag_c);
    dir_next_c  = ~shadow[CMD_W-1];
    dead_done_c = (cnt == CNT_W'(DEAD_CYCLES - 1));
  end

  // Next state, boundary load and PWM compare against the post-edge counter.
  always_comb begin
    state_n = state;
    load_c  = 1'b0;
    case (state)
      S_IDLE: begin
        if (en) begin
          state_n = S_RUN;
          load_c  = 1'b1;
        end
      end
      S_RUN: begin
        if (!en) begin
          state_n = S_IDLE;
        end else if (wrap_c) begin
          load_c = 1'b1;
`ifdef PWM_DEADTIME_EN
          if (dir_next_c != dir_out) state_n = S_DEAD;
`endif
        end
      end
      S_DEAD: begin
        if (!en) state_n = S_IDLE;
        else if (dead_done_c) state_n = S_RUN;
      end
      default: state_n = S_IDLE;
    endcase
    duty_n  = load_c ? duty_cmd_c : duty_active;
    dir_n   = load_c ? dir_next_c : dir_out;
    run_c   = (state_n != S_IDLE);
    clear_c = (state_n == S_IDLE) || (state == S_IDLE);
    pwm_n   = (state_n == S_RUN) && (cnt_next_c < duty_n);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      shadow      <= '0;
      duty_active <= '0;
      dir_out     <= 1'b1;
      pwm_out     <= 1'b0;
    end else begin
      state       <= state_n;
      shadow      <= Blance_pwm;
      duty_active <= duty_n;
      dir_out     <= dir_n;
      pwm_out     <= pwm_n;
    end
  end

endmodule
